// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone arbiter types: FSM state encoding, cycle/burst type codes,
// and an index-width helper that stays legal for a single master.
package peripheral_wb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/peripheral_arbiter_rr_wb.sv
// Combinational round-robin picker: first requester after 'last', wrapping,
// with 'last' itself considered only after every other master.
module peripheral_arbiter_rr_wb
  import peripheral_wb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  localparam int GW = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [GW-1:0]          last,
  output logic [GW-1:0]          grant,
  output logic                   valid
);

  always_comb begin
    int          idx;
    logic [GW-1:0] cand;
    idx   = 0;
    cand  = '0;
    grant = '0;
    valid = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx  = (int'(last) + k) % NUM_MASTERS;
      cand = GW'(idx);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/peripheral_arbiter_wb.sv
// Wishbone N:1 arbiter: round-robin grant held for the whole cyc, with a
// slave no-response watchdog that terminates a stuck beat with err.
//
//   state     | meaning
//   ARB_IDLE  | no owner; downstream port quiet, arbitrating on wbm_cyc_i
//   ARB_GRANT | grant_q owns the slave port until its cyc drops
module peripheral_arbiter_wb
  import peripheral_wb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 256
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_ni,
  input  logic [NUM_MASTERS-1:0][AW-1:0]  wbm_adr_i,
  input  logic [NUM_MASTERS-1:0][DW-1:0]  wbm_dat_i,
  input  logic [NUM_MASTERS-1:0][3:0]     wbm_sel_i,
  input  logic [NUM_MASTERS-1:0][2:0]     wbm_cti_i,
  input  logic [NUM_MASTERS-1:0][1:0]     wbm_bte_i,
  input  logic [NUM_MASTERS-1:0]          wbm_we_i,
  input  logic [NUM_MASTERS-1:0]          wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]          wbm_stb_i,
  output logic [NUM_MASTERS-1:0][DW-1:0]  wbm_dat_o,
  output logic [NUM_MASTERS-1:0]          wbm_ack_o,
  output logic [NUM_MASTERS-1:0]          wbm_err_o,
  output logic [NUM_MASTERS-1:0]          wbm_rty_o,
  output logic [AW-1:0]                   wbs_adr_o,
  output logic [DW-1:0]                   wbs_dat_o,
  output logic [3:0]                      wbs_sel_o,
  output logic                            wbs_we_o,
  output logic                            wbs_cyc_o,
  output logic                            wbs_stb_o,
  output logic [2:0]                      wbs_cti_o,
  output logic [1:0]                      wbs_bte_o,
  input  logic [DW-1:0]                   wbs_dat_i,
  input  logic                            wbs_ack_i,
  input  logic                            wbs_err_i,
  input  logic                            wbs_rty_i
);

  localparam int GW = idx_width(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] rr_grant;
  logic          rr_valid;
  logic          g_cyc, g_stb, resp, timeout_hit;

  peripheral_arbiter_rr_wb #(.NUM_MASTERS(NUM_MASTERS)) u_rr (
    .req   (wbm_cyc_i),
    .last  (last_q),
    .grant (rr_grant),
    .valid (rr_valid)
  );

  // last resets to the top index so master 0 wins the first arbitration
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = '0;
    timeout_hit = 1'b0;
    g_cyc       = wbm_cyc_i[grant_q];
    g_stb       = wbm_stb_i[grant_q];
    resp        = wbs_ack_i | wbs_err_i | wbs_rty_i;
    wbs_adr_o   = '0;
    wbs_dat_o   = '0;
    wbs_sel_o   = '0;
    wbs_we_o    = 1'b0;
    wbs_cyc_o   = 1'b0;
    wbs_stb_o   = 1'b0;
    wbs_cti_o   = '0;
    wbs_bte_o   = '0;
    wbm_ack_o   = '0;
    wbm_err_o   = '0;
    wbm_rty_o   = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      wbm_dat_o[m] = wb_rst_ni ? wbs_dat_i : '0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (rr_valid) begin
          grant_d = rr_grant;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!g_cyc) begin
          state_d = ARB_IDLE;
          last_d  = grant_q;
        end else begin
          if ((TIMEOUT > 0) && g_stb && !resp) begin
            if (cnt_q == TC) timeout_hit = 1'b1;
            else             cnt_d = cnt_q + CW'(1);
          end
          wbs_adr_o          = wbm_adr_i[grant_q];
          wbs_dat_o          = wbm_dat_i[grant_q];
          wbs_sel_o          = wbm_sel_i[grant_q];
          wbs_we_o           = wbm_we_i[grant_q];
          wbs_cti_o          = wbm_cti_i[grant_q];
          wbs_bte_o          = wbm_bte_i[grant_q];
          wbs_cyc_o          = 1'b1;
          wbs_stb_o          = g_stb & ~timeout_hit;
          wbm_ack_o[grant_q] = wbs_ack_i;
          wbm_err_o[grant_q] = wbs_err_i | timeout_hit;
          wbm_rty_o[grant_q] = wbs_rty_i;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// Directed + randomized bench for peripheral_arbiter_wb (2 masters, TIMEOUT=8)
// checked against a round-robin reference model kept in the bench.
module tb_peripheral_arbiter_wb;
  import peripheral_wb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0][AW-1:0] m_adr;
  logic [N-1:0][DW-1:0] m_dat;
  logic [N-1:0][3:0]    m_sel;
  logic [N-1:0][2:0]    m_cti;
  logic [N-1:0][1:0]    m_bte;
  logic [N-1:0]         m_we, m_cyc, m_stb;
  logic [N-1:0][DW-1:0] m_dat_o;
  logic [N-1:0]         m_ack, m_err, m_rty;
  logic [AW-1:0]        s_adr;
  logic [DW-1:0]        s_dat_o, s_dat_i;
  logic [3:0]           s_sel;
  logic                 s_we, s_cyc, s_stb;
  logic [2:0]           s_cti;
  logic [1:0]           s_bte;
  logic                 s_ack, s_err, s_rty;

  int tests = 0;
  int fails = 0;
  int model_last = N - 1;

  always #5 clk = ~clk;

  peripheral_arbiter_wb #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbm_adr_i (m_adr),
    .wbm_dat_i (m_dat),
    .wbm_sel_i (m_sel),
    .wbm_cti_i (m_cti),
    .wbm_bte_i (m_bte),
    .wbm_we_i  (m_we),
    .wbm_cyc_i (m_cyc),
    .wbm_stb_i (m_stb),
    .wbm_dat_o (m_dat_o),
    .wbm_ack_o (m_ack),
    .wbm_err_o (m_err),
    .wbm_rty_o (m_rty),
    .wbs_adr_o (s_adr),
    .wbs_dat_o (s_dat_o),
    .wbs_sel_o (s_sel),
    .wbs_we_o  (s_we),
    .wbs_cyc_o (s_cyc),
    .wbs_stb_o (s_stb),
    .wbs_cti_o (s_cti),
    .wbs_bte_o (s_bte),
    .wbs_dat_i (s_dat_i),
    .wbs_ack_i (s_ack),
    .wbs_err_i (s_err),
    .wbs_rty_i (s_rty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: first requester strictly after 'last', wrapping around.
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  task automatic clear_inputs();
    m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0; m_bte = '0;
    m_we = '0; m_cyc = '0; m_stb = '0;
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic set_master(input int m, input logic [2:0] cti);
    logic [31:0] r;
    r = $urandom();
    m_adr[m] = {r[31:12], 4'(m), r[7:0]};
    m_dat[m] = $urandom();
    m_sel[m] = 4'($urandom_range(1, 15));
    m_we[m]  = 1'($urandom_range(0, 1));
    m_cti[m] = cti;
    m_bte[m] = BTE_LINEAR;
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
  endtask

  task automatic check_grant_outputs(input int g);
    check("grant_adr", 64'(s_adr), 64'(m_adr[g]));
    check("grant_ctl", 64'({s_we, s_sel, s_cti, s_bte, s_dat_o}),
          64'({m_we[g], m_sel[g], m_cti[g], m_bte[g], m_dat[g]}));
  endtask

  // One arbitration round; call it on the cycle right after the previous drop.
  task automatic arb_round(input logic [N-1:0] add_req, input int beats,
                           input logic [2:0] cti, output int g_obs);
    int exp_g, waits, rsel;
    logic [N-1:0] oh;
    @(negedge clk);
    for (int m = 0; m < N; m++) if (add_req[m] && !m_cyc[m]) set_master(m, cti);
    #1;
    check("idle_cyc", 64'(s_cyc), 64'(0));
    check("idle_term", 64'({m_ack, m_err, m_rty}), 64'(0));
    exp_g = rr_pick(m_cyc, model_last);
    oh = N'(1) << exp_g;
    @(negedge clk); #1;
    g_obs = int'(s_adr[11:8]);
    check("grant_cyc", 64'(s_cyc), 64'(1));
    check("grant_idx", 64'(g_obs), 64'(exp_g));
    check_grant_outputs(exp_g);
    for (int b = 0; b < beats; b++) begin
      waits = $urandom_range(0, 3);
      for (int w = 0; w < waits; w++) begin
        m_stb[exp_g] = 1'($urandom_range(0, 1));
        #1;
        check("wait_stb", 64'({s_cyc, s_stb}), 64'({1'b1, m_stb[exp_g]}));
        check("wait_term", 64'({m_ack, m_err, m_rty}), 64'(0));
        @(negedge clk); #1;
      end
      m_stb[exp_g] = 1'b1;
      if (b > 0) m_adr[exp_g] = m_adr[exp_g] + 32'd4;
      rsel = $urandom_range(0, 5);
      s_ack = (rsel > 1);
      s_err = (rsel == 0);
      s_rty = (rsel == 1);
      s_dat_i = $urandom();
      #1;
      check("beat_adr", 64'(s_adr), 64'(m_adr[exp_g]));
      check("beat_term", 64'({m_ack, m_err, m_rty}),
            64'({s_ack ? oh : '0, s_err ? oh : '0, s_rty ? oh : '0}));
      check("beat_rdata", 64'(m_dat_o), 64'({N{s_dat_i}}));
      @(negedge clk); #1;
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    end
    m_cyc[exp_g] = 1'b0;
    m_stb[exp_g] = 1'b0;
    #1;
    check("drop_cyc_stb", 64'({s_cyc, s_stb}), 64'(0));
    model_last = exp_g;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_last = N - 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, exp_g, guard;
    logic [N-1:0] add, oh;

    // Reset state: even with requests and a response pending, all outputs 0.
    clear_inputs();
    set_master(0, CTI_CLASSIC);
    set_master(1, CTI_CLASSIC);
    s_ack = 1'b1; s_dat_i = 32'hdead_beef;
    #2;
    check("rst_slave", 64'({s_cyc, s_stb, s_we, s_adr}), 64'(0));
    check("rst_term", 64'({m_ack, m_err, m_rty}), 64'(0));
    check("rst_rdata", 64'(m_dat_o), 64'(0));
    clear_inputs();
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Master 0 alone: write 0x1234_5678 to 0x104.
    @(negedge clk);
    m_adr[0] = 32'h104; m_dat[0] = 32'h1234_5678; m_sel[0] = 4'hf;
    m_we[0] = 1'b1; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #1;
    check("m0_wr_wait", 64'(s_cyc), 64'(0));
    @(negedge clk); #1;
    check("m0_wr_cyc", 64'({s_cyc, s_stb, s_we}), 64'(3'b111));
    check("m0_wr_adr", 64'(s_adr), 64'(32'h104));
    check("m0_wr_dat", 64'(s_dat_o), 64'(32'h1234_5678));
    s_ack = 1'b1;
    #1;
    check("m0_wr_ack", 64'(m_ack), 64'(2'b01));
    @(negedge clk); #1;
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    check("m0_wr_drop", 64'({s_cyc, s_stb, m_ack}), 64'(0));
    model_last = 0;

    // Both masters contend three times after reset: order 0,1,0.
    do_reset();
    arb_round(2'b11, 1, CTI_CLASSIC, g);
    check("rr_order_0", 64'(g), 64'(0));
    arb_round(2'b01, 1, CTI_CLASSIC, g);
    check("rr_order_1", 64'(g), 64'(1));
    arb_round(2'b10, 1, CTI_CLASSIC, g);
    check("rr_order_2", 64'(g), 64'(0));

    // Master 1 (already waiting) runs a 4-beat burst while master 0 requests.
    arb_round(2'b01, 4, CTI_INCR, g);
    check("burst_owner", 64'(g), 64'(1));
    arb_round(2'b00, 1, CTI_CLASSIC, g);
    check("after_burst", 64'(g), 64'(0));

    // Lone master back-to-back.
    arb_round(2'b01, 1, CTI_CLASSIC, g);
    arb_round(2'b01, 2, CTI_CLASSIC, g);
    check("lone_regrant", 64'(g), 64'(0));

    // Randomized request patterns.
    for (int r = 0; r < 16; r++) begin
      add = N'($urandom_range(0, 3));
      if ((m_cyc | add) == '0) add = N'(1) << $urandom_range(0, N - 1);
      arb_round(add, $urandom_range(1, 3), ($urandom_range(0, 1) != 0) ? CTI_INCR : CTI_CLASSIC, g);
    end
    guard = 0;
    while (m_cyc != '0 && guard < 4) begin
      arb_round(2'b00, 1, CTI_CLASSIC, g);
      guard++;
    end
    check("drained", 64'(m_cyc), 64'(0));

    // Slave never answers: err on the 8th stb cycle, stb forced low there.
    @(negedge clk);
    set_master(1, CTI_CLASSIC);
    #1;
    check("to_idle", 64'(s_cyc), 64'(0));
    exp_g = rr_pick(m_cyc, model_last);
    oh = N'(1) << exp_g;
    @(negedge clk); #1;
    for (int c = 1; c <= 9; c++) begin
      if (c == TO) begin
        check("to_err", 64'(m_err), 64'(oh));
        check("to_stb", 64'({s_cyc, s_stb}), 64'(2'b10));
      end else begin
        check("to_noerr", 64'(m_err), 64'(0));
        check("to_stb_on", 64'({s_cyc, s_stb}), 64'(2'b11));
      end
      @(negedge clk); #1;
    end
    m_cyc[exp_g] = 1'b0; m_stb[exp_g] = 1'b0;
    #1;
    check("to_drop", 64'({s_cyc, s_stb}), 64'(0));
    model_last = exp_g;

    // Leave master 0 as the last owner, then reset in the middle of its burst.
    arb_round(2'b01, 1, CTI_CLASSIC, g);
    @(negedge clk);
    set_master(0, CTI_INCR);
    #1;
    @(negedge clk); #1;
    check("pre_rst_cyc", 64'({s_cyc, s_stb}), 64'(2'b11));
    s_ack = 1'b1; s_dat_i = $urandom();
    @(negedge clk); #1;
    m_adr[0] = m_adr[0] + 32'd4;
    rst_n = 1'b0;
    #1;
    check("mid_rst_slave", 64'({s_cyc, s_stb, s_adr}), 64'(0));
    check("mid_rst_term", 64'({m_ack, m_err, m_rty}), 64'(0));
    check("mid_rst_rdata", 64'(m_dat_o), 64'(0));
    clear_inputs();
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_last = N - 1;
    arb_round(2'b11, 2, CTI_INCR, g);
    check("rst_first_prio", 64'(g), 64'(0));
    arb_round(2'b00, 1, CTI_CLASSIC, g);
    check("rst_then_m1", 64'(g), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/peripheral_arbiter_wb.md
PERIPHERAL_ARBITER_WB -- requirements
Module: peripheral_arbiter_wb

Interface
REQ-001 Parameter NUM_MASTERS, default 2, SHALL set the number of Wishbone master ports (1..16).
REQ-002 Parameter AW, default 32, SHALL set the address width.
REQ-003 Parameter DW, default 32, SHALL set the data width.
REQ-004 Parameter TIMEOUT, default 256, SHALL set the slave no-response limit in cycles; 0 disables it.
REQ-005 wb_clk_i  in  1  SHALL be the single clock; the reset is asynchronous, active-low.
REQ-006 wb_rst_ni  in  1  SHALL be the asynchronous active-low reset.
REQ-007 wbm_adr_i/wbm_dat_i  in  [NUM_MASTERS][AW]/[NUM_MASTERS][DW]  SHALL carry per-master address and write data.
REQ-008 wbm_sel_i/wbm_cti_i/wbm_bte_i  in  [NUM_MASTERS][4]/[3]/[2]  SHALL carry per-master byte select, cycle type and burst type.
REQ-009 wbm_we_i/wbm_cyc_i/wbm_stb_i  in  [NUM_MASTERS]  SHALL carry per-master write enable, cycle and strobe.
REQ-010 wbm_dat_o  out  [NUM_MASTERS][DW]  SHALL return read data.
REQ-011 wbm_ack_o/wbm_err_o/wbm_rty_o  out  [NUM_MASTERS]  SHALL return per-master termination.
REQ-012 wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  AW/DW/4/1/1/1/3/2  SHALL drive the single downstream slave port (the bus-mux master input).
REQ-013 wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  DW/1/1/1  SHALL carry the slave response.

Function
REQ-014 Arbiter SHALL be a two-state FSM: IDLE, GRANT.
REQ-015 In IDLE, when any wbm_cyc_i is high, the arbiter SHALL register as grant the first requester searching from index last+1 upward, modulo NUM_MASTERS, and enter GRANT on the next edge.
REQ-016 wbs_cyc_o SHALL assert exactly one cycle after the winning wbm_cyc_i is sampled high in IDLE.
REQ-017 In GRANT, all wbs_* outputs SHALL be the granted master's inputs, combinationally, unless REQ-022 forces stb low.
REQ-018 In GRANT, wbs_ack_i/err_i/rty_i SHALL reach only the granted master; all other wbm_ack_o/err_o/rty_o SHALL be 0.
REQ-019 wbm_dat_o SHALL present wbs_dat_i on every master port.
REQ-020 Grant SHALL be held for as long as the granted wbm_cyc_i stays high, including across stb gaps and bursts (cti 3'b010).
REQ-021 When the granted wbm_cyc_i drops, FSM SHALL return to IDLE, store last = granted index, and drive wbs_cyc_o/wbs_stb_o low that same cycle; IDLE lasts at least one cycle.
REQ-022 If TIMEOUT>0, a counter SHALL increment each cycle wbs_cyc_o & wbs_stb_o are high with no ack/err/rty, and SHALL clear on any response or when stb is low. On reaching TIMEOUT, for exactly one cycle: wbm_err_o of the granted master SHALL be 1, wbs_stb_o SHALL be forced 0, and the counter SHALL clear.
REQ-023 Simultaneous requests from all masters SHALL be served in rotating order 0,1,..,N-1,0 with no starvation.
REQ-024 A lone master requesting back-to-back SHALL be re-granted after one IDLE cycle.
REQ-025 In IDLE, all wbs_* outputs SHALL be 0 and all wbm_ack_o/err_o/rty_o SHALL be 0.
REQ-026 NUM_MASTERS=1 SHALL be legal; grant is then always 0.

Reset
REQ-027 While wb_rst_ni is low, FSM SHALL be IDLE, the timeout counter 0, last = NUM_MASTERS-1 (master 0 wins first), and all outputs 0.
REQ-028 Reset asserted mid-transfer SHALL drop wbs_cyc_o/wbs_stb_o immediately, without waiting for a clock edge.

Structure
REQ-029 The FSM state enum and the CTI/BTE constants SHALL live in shared package peripheral_wb_pkg.
REQ-030 Round-robin selection SHALL be a combinational sub-module, peripheral_arbiter_rr_wb (inputs req, last; outputs grant index, valid).

Verification
REQ-031 Reset released, master 0 alone: write 0x1234_5678 to 0x104 -> wbs_cyc_o high one cycle after wbm_cyc_i, wbm_ack_o[0] pulses, wbm_ack_o[1] stays 0.
REQ-032 Both masters request in the same cycle, three times in a row -> grant order 0,1,0, with one IDLE cycle between grants.
REQ-033 Master 1 holds cyc through a 4-beat incrementing burst while master 0 requests -> master 0 is not granted until master 1's cyc drops.
REQ-034 Slave never answers, TIMEOUT=8 -> wbm_err_o of the granted master is 1 on the 8th cycle of stb, and wbs_stb_o is 0 in that cycle.
REQ-035 wb_rst_ni pulled low mid-burst -> all outputs 0 before the next edge; after release, master 0 has first priority.
